// File: rtl/riscv_decode_pkg.sv
// Shared RV32I decode constants and the mapped-address encoding used by the
// control ROM. Index 13 is deliberately left unused.
package riscv_decode_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [5:0] MA_NOP    = 6'd0;
  localparam logic [5:0] MA_BRANCH = 6'd0;
  localparam logic [5:0] MA_ADD    = 6'd1;
  localparam logic [5:0] MA_SUB    = 6'd2;
  localparam logic [5:0] MA_AND    = 6'd3;
  localparam logic [5:0] MA_OR     = 6'd4;
  localparam logic [5:0] MA_XOR    = 6'd5;
  localparam logic [5:0] MA_SLL    = 6'd6;
  localparam logic [5:0] MA_SRL    = 6'd7;
  localparam logic [5:0] MA_SRA    = 6'd8;
  localparam logic [5:0] MA_SLT    = 6'd9;
  localparam logic [5:0] MA_SLTU   = 6'd10;
  localparam logic [5:0] MA_LOAD   = 6'd11;
  localparam logic [5:0] MA_STORE  = 6'd12;
  localparam logic [5:0] MA_ADDI   = 6'd14;
  localparam logic [5:0] MA_SLTI   = 6'd15;
  localparam logic [5:0] MA_SLTIU  = 6'd16;
  localparam logic [5:0] MA_XORI   = 6'd17;
  localparam logic [5:0] MA_ORI    = 6'd18;
  localparam logic [5:0] MA_ANDI   = 6'd19;
  localparam logic [5:0] MA_SLLI   = 6'd20;
  localparam logic [5:0] MA_SRLI   = 6'd21;
  localparam logic [5:0] MA_SRAI   = 6'd22;
  localparam logic [5:0] MA_LUI    = 6'd23;
  localparam logic [5:0] MA_AUIPC  = 6'd24;
  localparam logic [5:0] MA_JAL    = 6'd25;
  localparam logic [5:0] MA_JALR   = 6'd26;

  typedef struct packed {
    logic [5:0] mapped_address;
    logic       illegal;
    logic       is_branch;
  } decode_t;

endpackage

// File: rtl/id_decode_stage_if.sv
// Fetch-side and control-side signals of the decode stage.
interface id_decode_stage_if #(parameter int XLEN = 32);
  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // the producer holds valid and payload stable until that edge.
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [5:0]      mapped_address;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic            is_branch;
  logic            illegal;

  modport master (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, mapped_address, rd, rs1, rs2,
           out_instr, out_pc, is_branch, illegal
  );

  modport slave (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, mapped_address, rd, rs1, rs2,
           out_instr, out_pc, is_branch, illegal
  );
endinterface

// File: rtl/decode_mapper.sv
// Combinational RV32I instruction to control-ROM index mapping.
module decode_mapper
  import riscv_decode_pkg::*;
(
    input  logic [31:0] instr,
    output logic [5:0]  mapped_address,
    output logic        illegal,
    output logic        is_branch
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;

    assign opcode        = instr[6:0];
    assign funct3        = instr[14:12];
    assign funct7        = instr[31:25];
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    always_comb begin
        mapped_address = MA_NOP;
        illegal        = 1'b0;
        is_branch      = 1'b0;
        unique case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    unique case (funct3)
                        F3_ADD_SUB: mapped_address = MA_ADD;
                        F3_SLL:     mapped_address = MA_SLL;
                        F3_SLT:     mapped_address = MA_SLT;
                        F3_SLTU:    mapped_address = MA_SLTU;
                        F3_XOR:     mapped_address = MA_XOR;
                        F3_SRL_SRA: mapped_address = MA_SRL;
                        F3_OR:      mapped_address = MA_OR;
                        F3_AND:     mapped_address = MA_AND;
                        default:    illegal = 1'b1;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
                    mapped_address = MA_SUB;
                end else if (funct7 == F7_ALT && funct3 == F3_SRL_SRA) begin
                    mapped_address = MA_SRA;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_OPIMM: begin
                unique case (funct3)
                    F3_ADD_SUB: mapped_address = MA_ADDI;
                    F3_SLT:     mapped_address = MA_SLTI;
                    F3_SLTU:    mapped_address = MA_SLTIU;
                    F3_XOR:     mapped_address = MA_XORI;
                    F3_OR:      mapped_address = MA_ORI;
                    F3_AND:     mapped_address = MA_ANDI;
                    F3_SLL: begin
                        if (funct7 == F7_BASE) mapped_address = MA_SLLI;
                        else                   illegal = 1'b1;
                    end
                    F3_SRL_SRA: begin
                        // Shift-immediates reuse funct7 to pick logical vs arithmetic
                        if (funct7 == F7_BASE)     mapped_address = MA_SRLI;
                        else if (funct7 == F7_ALT) mapped_address = MA_SRAI;
                        else                       illegal = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OPC_LOAD:   mapped_address = MA_LOAD;
            OPC_STORE:  mapped_address = MA_STORE;
            OPC_LUI:    mapped_address = MA_LUI;
            OPC_AUIPC:  mapped_address = MA_AUIPC;
            OPC_JAL:    mapped_address = MA_JAL;
            OPC_JALR: begin
                if (funct3 == F3_ADD_SUB) mapped_address = MA_JALR;
                else                      illegal = 1'b1;
            end
            OPC_BRANCH: begin
                mapped_address = MA_BRANCH;
                is_branch      = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_decode_stage.sv
// Registered decode stage: main + skid buffer between fetch and the control
// ROM, with all outputs and in_ready driven purely from registers.
module id_decode_stage
  import riscv_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    id_decode_stage_if.master  bus
);

    decode_t         in_dec;
    logic            in_fire;
    logic            out_fire;

    logic            main_valid;
    logic [XLEN-1:0] main_instr;
    logic [XLEN-1:0] main_pc;
    decode_t         main_dec;

    logic            skid_valid;
    logic [XLEN-1:0] skid_instr;
    logic [XLEN-1:0] skid_pc;
    decode_t         skid_dec;

    decode_mapper u_mapper (
        .instr          (bus.in_instr[31:0]),
        .mapped_address (in_dec.mapped_address),
        .illegal        (in_dec.illegal),
        .is_branch      (in_dec.is_branch)
    );

    assign bus.in_ready  = !skid_valid;
    assign in_fire       = bus.in_valid && !skid_valid;
    assign out_fire      = main_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_instr <= '0;
            main_pc    <= '0;
            main_dec   <= '0;
            skid_valid <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
            skid_dec   <= '0;
        end else if (flush) begin
            // Payload is left as-is; only the valids matter after a flush
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_fire) begin
            if (skid_valid) begin
                main_instr <= skid_instr;
                main_pc    <= skid_pc;
                main_dec   <= skid_dec;
                skid_valid <= 1'b0;
            end else if (in_fire) begin
                main_instr <= bus.in_instr;
                main_pc    <= bus.in_pc;
                main_dec   <= in_dec;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (!main_valid) begin
            if (in_fire) begin
                main_valid <= 1'b1;
                main_instr <= bus.in_instr;
                main_pc    <= bus.in_pc;
                main_dec   <= in_dec;
            end
        end else if (in_fire) begin
            skid_valid <= 1'b1;
            skid_instr <= bus.in_instr;
            skid_pc    <= bus.in_pc;
            skid_dec   <= in_dec;
        end
    end

    assign bus.out_valid      = main_valid;
    assign bus.out_instr      = main_instr;
    assign bus.out_pc         = main_pc;
    assign bus.mapped_address = main_dec.mapped_address;
    assign bus.illegal        = main_dec.illegal;
    assign bus.is_branch      = main_dec.is_branch;
    assign bus.rd             = main_instr[11:7];
    assign bus.rs1            = main_instr[19:15];
    assign bus.rs2            = main_instr[24:20];

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed bench for id_decode_stage: decode vectors, back-pressure, flush
// and asynchronous reset, checked with immediate assertions.
module tb_id_decode_stage;

    logic clk;
    logic rst_n;
    logic flush;
    int   vectors;
    int   miscompares;

    id_decode_stage_if #(.XLEN(32)) bus ();

    id_decode_stage #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_entry(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                             input logic [5:0] ma, input logic ill, input logic br);
        logic [31:0] w;
        w = instr;
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, ".mapped"},    32'(bus.mapped_address), 32'(ma));
        chk({tag, ".illegal"},   32'(bus.illegal), 32'(ill));
        chk({tag, ".is_branch"}, 32'(bus.is_branch), 32'(br));
        chk({tag, ".instr"},     bus.out_instr, instr);
        chk({tag, ".pc"},        bus.out_pc, pc);
        chk({tag, ".rd"},        32'(bus.rd), 32'(w[11:7]));
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, ".in_ready"},  32'(bus.in_ready), 32'd1);
        chk({tag, ".mapped"},    32'(bus.mapped_address), 32'd0);
        chk({tag, ".illegal"},   32'(bus.illegal), 32'd0);
        chk({tag, ".is_branch"}, 32'(bus.is_branch), 32'd0);
        chk({tag, ".instr"},     bus.out_instr, 32'd0);
        chk({tag, ".pc"},        bus.out_pc, 32'd0);
    endtask

    // Offer one instruction for exactly one edge, then check the registered result.
    task automatic single(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                          input logic [5:0] ma, input logic ill, input logic br);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_pc    = pc;
        tick();
        bus.in_valid = 1'b0;
        chk_entry(tag, instr, pc, ma, ill, br);
        tick();
        chk({tag, ".drained"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        rst_n          = 1'b1;
        flush          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_instr   = '0;
        bus.in_pc      = '0;
        bus.out_ready  = 1'b1;

        // Reset
        #1 rst_n = 1'b0;
        tick();
        tick();
        chk_reset_values("reset");
        #3 rst_n = 1'b1;
        tick();
        chk_reset_values("post_reset");

        // add x3,x1,x2 with explicit register checks
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h002081B3;
        bus.in_pc    = 32'h0000_1000;
        tick();
        bus.in_valid = 1'b0;
        chk("add.out_valid", 32'(bus.out_valid), 32'd1);
        chk("add.mapped",    32'(bus.mapped_address), 32'd1);
        chk("add.rd",        32'(bus.rd), 32'd3);
        chk("add.rs1",       32'(bus.rs1), 32'd1);
        chk("add.rs2",       32'(bus.rs2), 32'd2);
        chk("add.pc",        bus.out_pc, 32'h0000_1000);
        tick();
        chk("add.drained", 32'(bus.out_valid), 32'd0);

        single("sub",   32'h402081B3, 32'h0000_1004, 6'd2,  1'b0, 1'b0);
        single("srai",  32'h40335293, 32'h0000_1008, 6'd22, 1'b0, 1'b0);
        chk("srai.rs1", 32'(bus.rs1), 32'd6);
        single("lw",    32'h00012083, 32'h0000_100C, 6'd11, 1'b0, 1'b0);
        single("beq",   32'h00000463, 32'h0000_1010, 6'd0,  1'b0, 1'b1);
        single("ones",  32'hFFFFFFFF, 32'h0000_1014, 6'd0,  1'b1, 1'b0);
        single("op_f7", 32'h042081B3, 32'h0000_1018, 6'd0,  1'b1, 1'b0);
        single("jalr3", 32'h00001067, 32'h0000_101C, 6'd0,  1'b1, 1'b0);
        single("jalr",  32'h00008067, 32'h0000_1020, 6'd26, 1'b0, 1'b0);
        single("slli_bad", 32'h02009093, 32'h0000_1024, 6'd0, 1'b1, 1'b0);

        // Back-to-back throughput: ADDI then LUI, one per cycle
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h00108093;
        bus.in_pc    = 32'h0000_2000;
        tick();
        chk_entry("tput0", 32'h00108093, 32'h0000_2000, 6'd14, 1'b0, 1'b0);
        bus.in_instr = 32'h123450B7;
        bus.in_pc    = 32'h0000_2004;
        tick();
        bus.in_valid = 1'b0;
        chk_entry("tput1", 32'h123450B7, 32'h0000_2004, 6'd23, 1'b0, 1'b0);
        tick();
        chk("tput.drained", 32'(bus.out_valid), 32'd0);

        // Back-pressure: three offers while out_ready is low
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h002081B3;
        bus.in_pc     = 32'h0000_3000;
        tick();
        chk("bp.a.in_ready", 32'(bus.in_ready), 32'd1);
        chk_entry("bp.a", 32'h002081B3, 32'h0000_3000, 6'd1, 1'b0, 1'b0);
        bus.in_instr  = 32'h402081B3;
        bus.in_pc     = 32'h0000_3004;
        tick();
        chk("bp.b.in_ready", 32'(bus.in_ready), 32'd0);
        chk_entry("bp.hold1", 32'h002081B3, 32'h0000_3000, 6'd1, 1'b0, 1'b0);
        bus.in_instr  = 32'h00012083;
        bus.in_pc     = 32'h0000_3008;
        tick();
        chk("bp.c.in_ready", 32'(bus.in_ready), 32'd0);
        chk_entry("bp.hold2", 32'h002081B3, 32'h0000_3000, 6'd1, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        tick();
        chk_entry("bp.out_b", 32'h402081B3, 32'h0000_3004, 6'd2, 1'b0, 1'b0);
        chk("bp.drain.in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid  = 1'b0;
        chk_entry("bp.out_c", 32'h00012083, 32'h0000_3008, 6'd11, 1'b0, 1'b0);
        tick();
        chk("bp.empty", 32'(bus.out_valid), 32'd0);

        // Flush with main and skid full plus an input on offer
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h0000006F;
        bus.in_pc     = 32'h0000_4000;
        tick();
        bus.in_instr  = 32'h00000017;
        bus.in_pc     = 32'h0000_4004;
        tick();
        chk("fl.full.in_ready", 32'(bus.in_ready), 32'd0);
        chk_entry("fl.main", 32'h0000006F, 32'h0000_4000, 6'd25, 1'b0, 1'b0);
        bus.in_instr  = 32'h00000463;
        bus.in_pc     = 32'h0000_4008;
        flush         = 1'b1;
        tick();
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("fl.out_valid", 32'(bus.out_valid), 32'd0);
        chk("fl.in_ready",  32'(bus.in_ready), 32'd1);
        tick();
        chk("fl.later.out_valid", 32'(bus.out_valid), 32'd0);
        tick();
        chk("fl.later2.out_valid", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset in the middle of a stall
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h00012083;
        bus.in_pc     = 32'h0000_5000;
        tick();
        bus.in_instr  = 32'h402081B3;
        bus.in_pc     = 32'h0000_5004;
        tick();
        bus.in_valid  = 1'b0;
        chk("ar.stalled.in_ready", 32'(bus.in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_values("ar.async");
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        chk_reset_values("ar.released");
        single("ar.first", 32'h40335293, 32'h0000_6000, 6'd22, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
